// File: rtl/wb_ram_responder_pkg.sv
// Shared definitions for the Wishbone RAM responder: FSM state encoding,
// the full byte-lane mask and the address range helper.
package wb_ram_responder_pkg;

  typedef enum logic [1:0] {
    WB_IDLE   = 2'd0,
    WB_WAIT   = 2'd1,
    WB_ACCESS = 2'd2
  } wb_state_e;

  localparam logic [3:0] WB_SEL_ALL = 4'hf;

  // A word address is in range when nothing above the RAM index is set.
  function automatic logic addr_in_range(input logic [29:0] word_adr, input int aw);
    return (word_adr >> aw) == 30'd0;
  endfunction

endpackage

// File: rtl/wb_ram_responder_core.sv
// 32-bit single-port word RAM with per-byte write enables and a registered
// read port. Contents are deliberately not reset.
module wb_ram_core #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    byte_we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-lane writes and a registered read of the old word at the same edge.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (byte_we[n]) begin
        mem[addr][8*n +: 8] <= wdata[8*n +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/wb_ram_responder.sv
// Wishbone classic-cycle responder backed by an internal word RAM with a
// programmable number of wait states. Exactly one ack per accepted strobe.
// LATENCY must stay within 0..15 because the wait counter is 4 bits wide.
module wb_ram_responder
  import wb_ram_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int AW      = 10,
  parameter int LATENCY = 0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o
);

  localparam logic [3:0] LAT4 = 4'(LATENCY);

  wb_state_e   state;
  wb_state_e   next_state;
  logic [3:0]  cnt;
  logic [3:0]  next_cnt;
  logic        accept;

  logic [29:0] adr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic        ack_q;
  logic        rd_q;

  logic        in_range;
  logic [3:0]  byte_we;
  logic [31:0] ram_rdata;

  assign in_range = addr_in_range(adr_q, AW);
  assign byte_we  = (state == WB_ACCESS && we_q && in_range) ? (sel_q & WB_SEL_ALL) : 4'h0;

  // Next-state logic; IDLE refuses a strobe in the cycle its own ack is
  // visible so a master holding stb through the ack is not acked twice.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    accept     = 1'b0;
    case (state)
      WB_IDLE: begin
        if (wb_cyc_i && wb_stb_i && !ack_q) begin
          accept     = 1'b1;
          next_cnt   = LAT4;
          next_state = (LAT4 == 4'd0) ? WB_ACCESS : WB_WAIT;
        end
      end
      WB_WAIT: begin
        next_cnt = cnt - 4'd1;
        if (!wb_cyc_i) begin
          next_state = WB_IDLE;
          next_cnt   = 4'd0;
        end else if (cnt <= 4'd1) begin
          next_state = WB_ACCESS;
        end
      end
      WB_ACCESS: begin
        next_state = WB_IDLE;
      end
      default: begin
        next_state = WB_IDLE;
        next_cnt   = 4'd0;
      end
    endcase
  end

  // State, counter, latched request and the registered ack/read-valid flags.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= WB_IDLE;
      cnt   <= 4'd0;
      adr_q <= 30'd0;
      dat_q <= 32'd0;
      sel_q <= 4'h0;
      we_q  <= 1'b0;
      ack_q <= 1'b0;
      rd_q  <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (accept) begin
        adr_q <= wb_adr_i[31:2];
        dat_q <= wb_dat_i;
        sel_q <= wb_sel_i;
        we_q  <= wb_we_i;
      end
      ack_q <= (state == WB_ACCESS);
      rd_q  <= (state == WB_ACCESS) && !we_q && in_range;
    end
  end

  wb_ram_core #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_core (
    .clk    (sys_clk),
    .addr   (adr_q[AW-1:0]),
    .byte_we(byte_we),
    .wdata  (dat_q),
    .rdata  (ram_rdata)
  );

  assign wb_ack_o = ack_q;
  assign wb_dat_o = rd_q ? ram_rdata : 32'd0;

endmodule
